// File: rtl/mmio_timer_pkg.sv
// Shared register map, CTRL bit layout and CTRL struct for the MMIO timer slot.
package mmio_timer_pkg;

    localparam logic [4:0] REG_CTRL     = 5'd0;
    localparam logic [4:0] REG_PRESCALE = 5'd1;
    localparam logic [4:0] REG_COMPARE  = 5'd2;
    localparam logic [4:0] REG_COUNT    = 5'd3;
    localparam logic [4:0] REG_STATUS   = 5'd4;

    localparam int CTRL_EN     = 0;
    localparam int CTRL_AUTO   = 1;
    localparam int CTRL_IRQ_EN = 2;
    localparam int CTRL_W      = 3;

    // Field order matches the bit positions above (MSB first).
    typedef struct packed {
        logic irq_en;
        logic auto_reload;
        logic en;
    } ctrl_t;

endpackage

// File: rtl/timer_prescaler.sv
// Prescaler: emits a one-cycle tick every period+1 enabled clocks.
// Counter is held at 0 while disabled and restarts from 0 on clear.
module timer_prescaler #(
    parameter int PRESCALE_W = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  en,
    input  logic                  clear,
    input  logic [PRESCALE_W-1:0] period,
    output logic                  tick
);

    logic [PRESCALE_W-1:0] pre_cnt;

    assign tick = en && (pre_cnt == period);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pre_cnt <= '0;
        end else if (clear || !en || tick) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/mmio_timer_core.sv
// MMIO slot timer: prescaled 32-bit up-counter with compare match, sticky flag,
// auto-reload / one-shot modes and a level irq; rd_data is combinational.
module mmio_timer_core
    import mmio_timer_pkg::*;
#(
    parameter int PRESCALE_W = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cs,
    input  logic        read,
    input  logic        write,
    input  logic [4:0]  addr,
    input  logic [31:0] wr_data,
    output logic [31:0] rd_data,
    output logic        irq
);

    ctrl_t                 ctrl;
    logic [PRESCALE_W-1:0] prescale;
    logic [31:0]           compare;
    logic [31:0]           count;
    logic                  match;
    logic                  tick;

    logic wr_en, wr_ctrl, wr_prescale, wr_compare, wr_count, wr_status;
    logic hit;
    logic unused_read;

    // Reads have no side effects, so the strobe is accepted but not used.
    assign unused_read = read;

    assign wr_en       = cs && write;
    assign wr_ctrl     = wr_en && (addr == REG_CTRL);
    assign wr_prescale = wr_en && (addr == REG_PRESCALE);
    assign wr_compare  = wr_en && (addr == REG_COMPARE);
    assign wr_count    = wr_en && (addr == REG_COUNT);
    assign wr_status   = wr_en && (addr == REG_STATUS);

    // A COUNT write in a tick cycle suppresses match evaluation entirely.
    assign hit = tick && !wr_count && (count == compare);

    timer_prescaler #(
        .PRESCALE_W(PRESCALE_W)
    ) u_prescaler (
        .clk    (clk),
        .reset_n(reset_n),
        .en     (ctrl.en),
        .clear  (wr_count || wr_prescale),
        .period (prescale),
        .tick   (tick)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctrl     <= '0;
            prescale <= '0;
            compare  <= '0;
        end else begin
            if (wr_ctrl) begin
                ctrl <= ctrl_t'(wr_data[CTRL_W-1:0]);
            end else if (hit && !ctrl.auto_reload) begin
                ctrl.en <= 1'b0;
            end
            if (wr_prescale) begin
                prescale <= wr_data[PRESCALE_W-1:0];
            end
            if (wr_compare) begin
                compare <= wr_data;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (wr_count) begin
            count <= '0;
        end else if (hit) begin
            if (ctrl.auto_reload) begin
                count <= '0;
            end
        end else if (tick) begin
            count <= count + 32'd1;
        end
    end

    // Set has priority over a same-cycle software clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            match <= 1'b0;
        end else if (hit) begin
            match <= 1'b1;
        end else if (wr_status && wr_data[0]) begin
            match <= 1'b0;
        end
    end

    always_comb begin
        rd_data = '0;
        case (addr)
            REG_CTRL:     rd_data[CTRL_W-1:0]     = ctrl;
            REG_PRESCALE: rd_data[PRESCALE_W-1:0] = prescale;
            REG_COMPARE:  rd_data                 = compare;
            REG_COUNT:    rd_data                 = count;
            REG_STATUS:   rd_data[0]              = match;
            default:      rd_data                 = '0;
        endcase
    end

    assign irq = match && ctrl.irq_en;

endmodule
